// File: rtl/line_buffer_fifo.sv
// Line-oriented FIFO: writes build whole lines in fixed slots, reads stream them back with eol_out.
// Define LINE_BUFFER_FIFO_STATS_EN to add the saturating dropped_lines counter output.
module line_buffer_fifo #(
    parameter int DATA_W    = 8,
    parameter int LINE_SIZE = 1440,
    parameter int NUM_LINES = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              data_in,
    input  logic                           write,
    input  logic                           eol_in,
    input  logic                           read,
    output logic [DATA_W-1:0]              data_out,
    output logic                           valid_out,
    output logic                           eol_out,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(NUM_LINES+1)-1:0] lines_used
`ifdef LINE_BUFFER_FIFO_STATS_EN
    ,
    output logic [15:0]                    dropped_lines
`endif
);
    localparam int IDX_W  = $clog2(LINE_SIZE);
    localparam int SLOT_W = $clog2(NUM_LINES);
    localparam int DEPTH  = NUM_LINES * LINE_SIZE;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(NUM_LINES+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  last_idx [NUM_LINES];  // stored length minus one, per slot
    logic [SLOT_W-1:0] head, tail;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              drop_mode;

    logic              wr_accept, wr_line_end, commit;
    logic              rd_accept, rd_last, release_line;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return (s == SLOT_W'(NUM_LINES-1)) ? '0 : s + 1'b1;
    endfunction

    assign full  = (lines_used == CNT_W'(NUM_LINES));
    assign empty = (lines_used == '0);

    // wr_idx also counts discarded words so a dropped line ends at the same boundary
    assign wr_accept    = write && !full && !drop_mode;
    assign wr_line_end  = eol_in || (wr_idx == IDX_W'(LINE_SIZE-1));
    assign commit       = wr_accept && wr_line_end;
    assign rd_accept    = read && !empty;
    assign rd_last      = (rd_idx == last_idx[tail]);
    assign release_line = rd_accept && rd_last;

    assign wr_addr = ADDR_W'(head) * ADDR_W'(LINE_SIZE) + ADDR_W'(wr_idx);
    assign rd_addr = ADDR_W'(tail) * ADDR_W'(LINE_SIZE) + ADDR_W'(rd_idx);

    always_ff @(posedge clock) begin
        if (wr_accept)
            mem[wr_addr] <= data_in;
        if (commit)
            last_idx[head] <= wr_idx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            drop_mode  <= 1'b0;
            lines_used <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            eol_out    <= 1'b0;
        end else begin
            if (write) begin
                if (wr_line_end) begin
                    wr_idx    <= '0;
                    drop_mode <= 1'b0;
                    if (commit)
                        head <= next_slot(head);
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                    if (!wr_accept)
                        drop_mode <= 1'b1;
                end
            end

            if (rd_accept) begin
                data_out  <= mem[rd_addr];
                valid_out <= 1'b1;
                eol_out   <= rd_last;
                if (rd_last) begin
                    rd_idx <= '0;
                    tail   <= next_slot(tail);
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end else begin
                valid_out <= 1'b0;
                eol_out   <= 1'b0;
            end

            case ({commit, release_line})
                2'b10:   lines_used <= lines_used + 1'b1;
                2'b01:   lines_used <= lines_used - 1'b1;
                default: lines_used <= lines_used;
            endcase
        end
    end

`ifdef LINE_BUFFER_FIFO_STATS_EN
    // Counted on the first discarded word, i.e. when a line enters drop mode
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            dropped_lines <= '0;
        else if (write && full && !drop_mode && dropped_lines != 16'hFFFF)
            dropped_lines <= dropped_lines + 16'd1;
    end
`endif

endmodule

// File: tb/tb_line_buffer_fifo.sv
// Scoreboard bench for line_buffer_fifo (DATA_W=8, LINE_SIZE=4, NUM_LINES=3).
module tb_line_buffer_fifo;
    localparam int DW = 8;
    localparam int LS = 4;
    localparam int NL = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          write, eol_in, read;
    logic [DW-1:0] data_out;
    logic          valid_out, eol_out, full, empty;
    logic [1:0]    lines_used;
`ifdef LINE_BUFFER_FIFO_STATS_EN
    logic [15:0]   dropped_lines;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW:0] exp_q[$];  // {eol, data}

    line_buffer_fifo #(.DATA_W(DW), .LINE_SIZE(LS), .NUM_LINES(NL)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .write(write),
        .eol_in(eol_in), .read(read), .data_out(data_out), .valid_out(valid_out),
        .eol_out(eol_out), .full(full), .empty(empty), .lines_used(lines_used)
`ifdef LINE_BUFFER_FIFO_STATS_EN
        , .dropped_lines(dropped_lines)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic e);
        write = 1'b1; data_in = d; eol_in = e;
        tick();
        write = 1'b0; eol_in = 1'b0;
    endtask

    task automatic rd(input logic expect_out, input logic [DW-1:0] d, input logic e);
        if (expect_out)
            exp_q.push_back({e, d});
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    // Monitor: every presented word must match the oldest expectation
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clock);
            if (!reset && valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid_out}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", {24'd0, data_out}, {24'd0, e[DW-1:0]});
                    check("eol_out", {31'd0, eol_out}, {31'd0, e[DW]});
                end
            end
        end
    end

    initial begin
        reset = 1'b1; write = 1'b0; eol_in = 1'b0; read = 1'b0; data_in = '0;
        tick(); tick();
        check("rst_lines_used", {30'd0, lines_used}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_eol", {31'd0, eol_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        reset = 1'b0;
        tick();

        // Line ended by size
        wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0); wr(8'h44, 0);
        check("s1_lines_used", {30'd0, lines_used}, 32'd1);
        rd(1, 8'h11, 0); rd(1, 8'h22, 0); rd(1, 8'h33, 0); rd(1, 8'h44, 1);
        check("s1_lines_after", {30'd0, lines_used}, 32'd0);
        check("s1_empty", {31'd0, empty}, 32'd1);

        // Line ended by eol, extra read ignored
        wr(8'h55, 0); wr(8'h66, 1);
        rd(1, 8'h55, 0); rd(1, 8'h66, 1); rd(0, 8'h00, 0);
        check("s2_ign_valid", {31'd0, valid_out}, 32'd0);
        check("s2_hold_data", {24'd0, data_out}, 32'h66);

        // Fill all slots, then a line is dropped
        wr(8'h01, 0); wr(8'h02, 1);
        wr(8'h03, 1);
        wr(8'h04, 0); wr(8'h05, 0); wr(8'h06, 0); wr(8'h07, 0);
        check("s3_full", {31'd0, full}, 32'd1);
        check("s3_lines", {30'd0, lines_used}, 32'd3);
        wr(8'hAA, 0); wr(8'hBB, 1);
        check("s3_lines_drop", {30'd0, lines_used}, 32'd3);
`ifdef LINE_BUFFER_FIFO_STATS_EN
        check("s3_dropped", {16'd0, dropped_lines}, 32'd1);
`endif

        // Drop mode persists after space frees mid-line
        wr(8'hAA, 0);
        rd(1, 8'h01, 0); rd(1, 8'h02, 1);
        check("s4_not_full", {31'd0, full}, 32'd0);
        wr(8'hBB, 0); wr(8'hCC, 1);
        check("s4_lines_held", {30'd0, lines_used}, 32'd2);
        wr(8'hDD, 1);
        check("s4_lines_dd", {30'd0, lines_used}, 32'd3);
`ifdef LINE_BUFFER_FIFO_STATS_EN
        check("s4_dropped", {16'd0, dropped_lines}, 32'd2);
`endif
        rd(1, 8'h03, 1);
        rd(1, 8'h04, 0); rd(1, 8'h05, 0); rd(1, 8'h06, 0); rd(1, 8'h07, 1);
        rd(1, 8'hDD, 1);
        check("s4_drained", {30'd0, lines_used}, 32'd0);

        // Release and commit in the same cycle
        wr(8'hE1, 0); wr(8'hE2, 1);
        rd(1, 8'hE1, 0);
        exp_q.push_back({1'b1, 8'hE2});
        read = 1'b1; write = 1'b1; data_in = 8'hF1; eol_in = 1'b1;
        tick();
        read = 1'b0; write = 1'b0; eol_in = 1'b0;
        check("s5_lines_same", {30'd0, lines_used}, 32'd1);
        rd(1, 8'hF1, 1);
        check("s5_lines_after", {30'd0, lines_used}, 32'd0);

        // Reset mid-line with two lines committed
        wr(8'h31, 1); wr(8'h32, 1); wr(8'h33, 0);
        check("s6_lines_pre", {30'd0, lines_used}, 32'd2);
        reset = 1'b1;
        tick();
        check("s6_empty", {31'd0, empty}, 32'd1);
        check("s6_lines", {30'd0, lines_used}, 32'd0);
        check("s6_valid", {31'd0, valid_out}, 32'd0);
        check("s6_full", {31'd0, full}, 32'd0);
        reset = 1'b0;
        tick();
        wr(8'h41, 0); wr(8'h42, 0); wr(8'h43, 1);
        check("s6_lines_new", {30'd0, lines_used}, 32'd1);
        rd(1, 8'h41, 0); rd(1, 8'h42, 0); rd(1, 8'h43, 1);
        rd(0, 8'h00, 0);

        tick(); tick(); tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
